// File: rtl/dqn_weight_load_receiver.sv
// dqn_weight_load_receiver: checks the DQN weight-load stream and forwards accepted words to the layer weight RAMs.
// Optional WEIGHT_CHECKSUM_EN adds o_checksum, a wrap-around sum of the weights accepted in the current load.
module dqn_weight_load_receiver #(
  parameter int DATA_WIDTH = 32,
  parameter int LAYER_WIDTH = 2,
  parameter int WEIGHT_COUNTER_WIDTH = 11,
  parameter int NUMBER_OF_INPUT_NODE = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_weight_valid,
  input  logic [LAYER_WIDTH-1:0] i_weight_layer,
  input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_weight_addr,
  input  logic [DATA_WIDTH-1:0] i_weight,
`ifdef WEIGHT_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] o_checksum,
`endif
  output logic o_wr_en_h1,
  output logic o_wr_en_h2,
  output logic o_wr_en_out,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic o_load_done,
  output logic o_weights_ready,
  output logic o_error
);
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] N1 =
    WEIGHT_COUNTER_WIDTH'(NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1));
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] N2 =
    WEIGHT_COUNTER_WIDTH'(NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1));
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] N3 =
    WEIGHT_COUNTER_WIDTH'(NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1));
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] ONE = WEIGHT_COUNTER_WIDTH'(1);
  localparam logic [LAYER_WIDTH-1:0] LY1 = LAYER_WIDTH'(1);
  localparam logic [LAYER_WIDTH-1:0] LY2 = LAYER_WIDTH'(2);
  localparam logic [LAYER_WIDTH-1:0] LY3 = LAYER_WIDTH'(3);
  typedef enum logic [2:0] {IDLE, L1, L2, L3, DONE, ERR} state_t;
  state_t state, nxt;
  logic [WEIGHT_COUNTER_WIDTH-1:0] cnt, cnt_nxt;
  logic beat, entry, same, succ, acc, fin;
  logic [2:0] wr_nxt;
  always_comb begin
    beat = i_weight_valid && i_weight_layer != '0;
    entry = i_weight_layer == LY1 && i_weight_addr == '0 && (state == IDLE || state == DONE || state == ERR);
    same = i_weight_addr == cnt &&
      ((state == L1 && i_weight_layer == LY1 && cnt < N1) ||
       (state == L2 && i_weight_layer == LY2 && cnt < N2) ||
       (state == L3 && i_weight_layer == LY3 && cnt < N3));
    succ = i_weight_addr == '0 &&
      ((state == L1 && i_weight_layer == LY2 && cnt == N1) ||
       (state == L2 && i_weight_layer == LY3 && cnt == N2));
    acc = beat && (entry || same || succ);
    fin = acc && same && state == L3 && cnt + ONE == N3;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
    end
  end
  // Entry and layer hand-over both consume address 0, so the counter restarts at 1.
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    if (beat && !acc) nxt = ERR;
    else if (acc && entry) begin
      nxt = L1;
      cnt_nxt = ONE;
    end else if (acc && succ) begin
      nxt = state == L1 ? L2 : L3;
      cnt_nxt = ONE;
    end else if (acc) begin
      nxt = fin ? DONE : state;
      cnt_nxt = cnt + ONE;
    end
  end
  always_comb begin
    wr_nxt = acc ? {i_weight_layer == LY3, i_weight_layer == LY2, i_weight_layer == LY1} : 3'b000;
    o_weights_ready = state == DONE;
    o_error = state == ERR;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {o_wr_en_out, o_wr_en_h2, o_wr_en_h1} <= '0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_load_done <= 1'b0;
    end else begin
      {o_wr_en_out, o_wr_en_h2, o_wr_en_h1} <= wr_nxt;
      o_wr_addr <= acc ? i_weight_addr : o_wr_addr;
      o_wr_data <= acc ? i_weight : o_wr_data;
      o_load_done <= fin;
    end
  end
`ifdef WEIGHT_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_checksum <= '0;
    else if (acc) o_checksum <= entry ? i_weight : o_checksum + i_weight;
  end
`endif
endmodule
